whack_game_core: RTL and testbench

- Parametrised whack-a-mole game engine: mode selection, start countdown, timed play round, mole placement, whack detection and scoring, all in one clock domain.
- Replaces the separate clock-divider, mode, countdown, timer, mole, whack and score blocks with one FSM driven by an internal tick prescaler.
- Outputs LED mole pattern, score and remaining time to the display path (binary-to-BCD and seven-segment logic, outside this block).

---
 rtl/whack_game_core.sv | 180 ++++++++++++++++++
 tb/tb_whack_game_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/whack_game_core.sv
// Whack-a-mole engine: mode select, countdown, timed round, LFSR mole placement and scoring.
// Optional build macro WHACK_MISS_PENALTY_EN: a toggle on a dark position costs one point.
module whack_game_core #(
    parameter int          NUM_MOLES   = 16,
    parameter int          SCORE_W     = 16,
    parameter int          TICK_DIV    = 10_000_000,
    parameter int          COUNTDOWN_S = 3,
    parameter int          GAME_S      = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [3:0]           buttons_i,
    input  logic [NUM_MOLES-1:0] switches_i,
    output logic [NUM_MOLES-1:0] LEDs_o,
    output logic [SCORE_W-1:0]   score_o,
    output logic [7:0]           time_o,
    output logic [1:0]           mode_o,
    output logic [1:0]           state_o,
    output logic                 game_over_o
);
    localparam int IDX_W = $clog2(NUM_MOLES);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CD   = 2'b01;
    localparam logic [1:0] S_PLAY = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;
    localparam logic [NUM_MOLES-1:0] ONE_HOT0 = NUM_MOLES'(1);

    logic [1:0]           state_q, state_d, mode_q, mode_d;
    logic [NUM_MOLES-1:0] leds_q, leds_d, sw_q;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [7:0]           time_q, time_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [3:0]           sub_q, sub_d, mole_q, mole_d;
    logic [IDX_W-1:0]     idx_q, idx_d, new_idx;
    logic [15:0]          lfsr_q;
    logic [3:0]           btn_q, btn_rise, period_m1;
    logic [NUM_MOLES-1:0] toggle;
    logic                 tick, sec, hit, period_end;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (&s) ? s : s + 1'b1;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] s);
        return (s == '0) ? s : s - 1'b1;
    endfunction

    // Galois LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    assign tick       = (pre_q == PRE_W'(TICK_DIV - 1));
    assign sec        = tick && (sub_q == 4'd9);
    assign btn_rise   = buttons_i & ~btn_q;
    assign toggle     = switches_i ^ sw_q;
    assign hit        = |(toggle & leds_q);
    assign period_end = tick && (mole_q == period_m1);
    // A respawn never reuses the index of the previous mole, lit or already hit
    assign new_idx    = (lfsr_q[IDX_W-1:0] == idx_q) ? lfsr_q[IDX_W-1:0] + 1'b1
                                                     : lfsr_q[IDX_W-1:0];

    always_comb begin
        case (mode_q)
            2'b01:   period_m1 = 4'd9;
            2'b10:   period_m1 = 4'd1;
            default: period_m1 = 4'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        leds_d  = leds_q;
        score_d = score_q;
        time_d  = time_q;
        idx_d   = idx_q;
        mole_d  = mole_q;
        pre_d   = tick ? '0 : pre_q + 1'b1;
        sub_d   = tick ? ((sub_q == 4'd9) ? 4'd0 : sub_q + 4'd1) : sub_q;
        case (state_q)
            S_IDLE: begin
                if (btn_rise[2])      mode_d = 2'b11;
                else if (btn_rise[1]) mode_d = 2'b10;
                else if (btn_rise[0]) mode_d = 2'b01;
                if (btn_rise[3] && mode_q != 2'b00) begin
                    state_d = S_CD;
                    time_d  = 8'(COUNTDOWN_S);
                    pre_d   = '0;
                    sub_d   = '0;
                end
            end
            S_CD: begin
                if (sec) begin
                    if (time_q == 8'd1) begin
                        state_d = S_PLAY;
                        time_d  = 8'(GAME_S);
                        score_d = '0;
                        idx_d   = lfsr_q[IDX_W-1:0];
                        leds_d  = ONE_HOT0 << lfsr_q[IDX_W-1:0];
                        pre_d   = '0;
                        sub_d   = '0;
                        mole_d  = '0;
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                if (hit) begin
                    score_d = sat_inc(score_q);
                    leds_d  = '0;
                end
`ifdef WHACK_MISS_PENALTY_EN
                else if (|(toggle & ~leds_q)) begin
                    score_d = sat_dec(score_q);
                end
`endif
                if (tick) mole_d = period_end ? 4'd0 : mole_q + 4'd1;
                if (period_end) begin
                    idx_d  = new_idx;
                    leds_d = ONE_HOT0 << new_idx;
                end
                if (sec) begin
                    if (time_q == 8'd1) begin
                        time_d  = 8'd0;
                        state_d = S_DONE;
                        leds_d  = '0;
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end
            end
            default: begin
                if (btn_rise[3]) begin
                    state_d = S_IDLE;
                    score_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        sw_q <= switches_i;
        if (reset_i) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            leds_q  <= '0;
            score_q <= '0;
            time_q  <= 8'd0;
            pre_q   <= '0;
            sub_q   <= 4'd0;
            mole_q  <= 4'd0;
            idx_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            btn_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            leds_q  <= leds_d;
            score_q <= score_d;
            time_q  <= time_d;
            pre_q   <= pre_d;
            sub_q   <= sub_d;
            mole_q  <= mole_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_step(lfsr_q);
            btn_q   <= buttons_i;
        end
    end

    assign LEDs_o      = leds_q;
    assign score_o     = score_q;
    assign time_o      = time_q;
    assign mode_o      = mode_q;
    assign state_o     = state_q;
    assign game_over_o = (state_q == S_DONE);
endmodule

// File: tb/tb_whack_game_core.sv
// Directed bench for whack_game_core: expectations queued with each stimulus step, popped at sampling.
module tb_whack_game_core;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef WHACK_MISS_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  buttons_i;
    logic [15:0] switches_i;
    logic [15:0] LEDs_o;
    logic [15:0] score_o;
    logic [7:0]  time_o;
    logic [1:0]  mode_o, state_o;
    logic        game_over_o;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] m_lfsr;

    whack_game_core #(
        .NUM_MOLES(16), .SCORE_W(16), .TICK_DIV(2),
        .COUNTDOWN_S(3), .GAME_S(5), .LFSR_SEED(SEED)
    ) dut (
        .clock_i(clk), .reset_i(reset_i), .buttons_i(buttons_i),
        .switches_i(switches_i), .LEDs_o(LEDs_o), .score_o(score_o),
        .time_o(time_o), .mode_o(mode_o), .state_o(state_o),
        .game_over_o(game_over_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] s, input int n);
        logic [15:0] r = s;
        for (int i = 0; i < n; i++) r = nxt(r);
        return r;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'h0001 << i;
    endfunction

    function automatic logic [3:0] respawn(input logic [15:0] l, input logic [3:0] prev);
        return (l[3:0] == prev) ? prev + 4'd1 : l[3:0];
    endfunction

    // Reference copy of the mole LFSR, advancing on the same edges as the design
    always @(posedge clk) m_lfsr <= reset_i ? SEED : nxt(m_lfsr);

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0]  p, prev, pred, p0, p2, p3, p4, p5;
    logic [15:0] a60, a80;
    logic        found;

    initial begin
        reset_i = 1'b1; buttons_i = 4'b0000; switches_i = 16'h0000;
        push("rst_state", 0); push("rst_mode", 0); push("rst_leds", 0);
        push("rst_score", 0); push("rst_time", 0); push("rst_over", 0);
        step(2);
        chk(state_o); chk(mode_o); chk(LEDs_o); chk(score_o); chk(time_o); chk(game_over_o);
        reset_i = 1'b0;
        step(1);

        // ---------------- game 1: medium ----------------
        push("start_without_mode", 0);
        buttons_i = 4'b1000; step(1); chk(state_o); buttons_i = 4'b0000; step(1);
        push("mode_priority", 3);
        buttons_i = 4'b0101; step(1); chk(mode_o); buttons_i = 4'b0000; step(1);
        push("mode_medium", 2); push("idle_state", 0);
        buttons_i = 4'b0010; step(1); chk(mode_o); chk(state_o); buttons_i = 4'b0000; step(1);
        push("cd_state", 1); push("cd_time3", 3);
        buttons_i = 4'b1000; step(1); chk(state_o); chk(time_o); buttons_i = 4'b0000;
        push("cd_time3_hold", 3); step(19); chk(time_o);
        push("cd_time2", 2);      step(1);  chk(time_o);
        push("cd_time1", 1);      step(20); chk(time_o);
        push("cd_last_cycle", 1); step(19); chk(state_o);
        p = m_lfsr[3:0];
        push("play_state", 2); push("play_time", 5); push("play_score", 0); push("first_mole", oh(p));
        step(1); chk(state_o); chk(time_o); chk(score_o); chk(LEDs_o);
        push("hit_score", 1); push("hit_dark", 0);
        switches_i ^= oh(p); step(1); chk(score_o); chk(LEDs_o);
        push("play_time5_hold", 5); step(18); chk(time_o);
        push("play_time4", 4);      step(1);  chk(time_o);
        push("play_last_cycle", 2); step(79); chk(state_o);
        push("done_state", 3); push("done_over", 1); push("done_leds", 0);
        push("done_time", 0); push("done_score", 1); push("done_mode", 2);
        step(1); chk(state_o); chk(game_over_o); chk(LEDs_o); chk(time_o); chk(score_o); chk(mode_o);
        push("done_frozen_score", 1); push("done_frozen_state", 3);
        switches_i ^= 16'h0F0F; step(3); chk(score_o); chk(state_o);
        push("restart_state", 0); push("restart_score", 0); push("restart_mode", 2); push("restart_over", 0);
        buttons_i = 4'b1000; step(1); chk(state_o); chk(score_o); chk(mode_o); chk(game_over_o);
        buttons_i = 4'b0000; step(1);

        // ---------------- game 2: easy, forced collision ----------------
        push("mode_easy", 1);
        buttons_i = 4'b0001; step(1); chk(mode_o); buttons_i = 4'b0000; step(1);
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            a60 = adv(m_lfsr, 60);
            a80 = adv(a60, 20);
            if (a60[3:0] == 4'd15 && a80[3:0] == 4'd15) found = 1'b1;
            else step(1);
        end
        push("collision_search", 1); chk(found);
        push("easy_cd", 1);
        buttons_i = 4'b1000; step(1); chk(state_o); buttons_i = 4'b0000;
        step(59);
        prev = m_lfsr[3:0];
        push("easy_first_mole", oh(prev)); step(1); chk(LEDs_o);
        for (int k = 1; k <= 4; k++) begin
            push("mole_hold", oh(prev)); step(19); chk(LEDs_o);
            pred = respawn(m_lfsr, prev);
            push("mole_move", oh(pred)); step(1); chk(LEDs_o);
            prev = pred;
        end
        push("easy_done_state", 3); push("easy_done_leds", 0);
        step(20); chk(state_o); chk(LEDs_o);
        push("easy_restart", 0);
        buttons_i = 4'b1000; step(1); chk(state_o); buttons_i = 4'b0000; step(1);

        // ---------------- game 3: hard, hits and misses ----------------
        push("mode_hard", 3);
        buttons_i = 4'b0100; step(1); chk(mode_o); buttons_i = 4'b0000; step(1);
        push("hard_cd", 1);
        buttons_i = 4'b1000; step(1); chk(state_o); buttons_i = 4'b0000;
        step(4);
        push("mode_locked", 3);
        buttons_i = 4'b0001; step(1); chk(mode_o); buttons_i = 4'b0000;
        step(54);
        p0 = m_lfsr[3:0];
        push("hard_first_mole", oh(p0)); push("hard_score0", 0);
        step(1); chk(LEDs_o); chk(score_o);
        push("miss_at_zero", 0);
        switches_i ^= oh(p0 + 4'd5); step(1); chk(score_o);
        p2 = respawn(m_lfsr, p0);
        push("hard_mole2", oh(p2)); step(1); chk(LEDs_o);
        push("hard_hit1", 1); push("hard_hit1_dark", 0);
        switches_i ^= oh(p2); step(1); chk(score_o); chk(LEDs_o);
        p3 = respawn(m_lfsr, p2);
        push("hard_mole3", oh(p3)); step(1); chk(LEDs_o);
        push("multi_toggle_score", 2); push("multi_toggle_dark", 0);
        switches_i ^= oh(p3) | oh(p3 + 4'd3) | oh(p3 + 4'd7); step(1); chk(score_o); chk(LEDs_o);
        p4 = respawn(m_lfsr, p3);
        push("hard_mole4", oh(p4)); step(1); chk(LEDs_o);
        step(1);
        p5 = respawn(m_lfsr, p4);
        push("hit_with_respawn_score", 3); push("hit_with_respawn_led", oh(p5));
        switches_i ^= oh(p4); step(1); chk(score_o); chk(LEDs_o);
        push("miss_penalty", PEN ? 2 : 3);
        switches_i ^= oh(p5 + 4'd1); step(1); chk(score_o);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
